// File: rtl/sevenseg_scan_mux.sv
// Seven-segment scan multiplexer: snapshots all digit patterns once per frame and
// drives them one digit at a time onto a shared segment bus. Optional macro SEVENSEG_DEADTIME_EN.
module sevenseg_scan_mux #(
  parameter int unsigned NUM_DISPLAYS      = 4,
  parameter int unsigned SCAN_DIVISIONBITS = 16,
  parameter int unsigned DEADTIME_CYCLES   = 64,
  parameter bit          SEG_ACTIVE_LOW    = 1'b1,
  parameter bit          DIGIT_ACTIVE_LOW  = 1'b1
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic [NUM_DISPLAYS-1:0][6:0] data,
  output logic [6:0]                   seg,
  output logic [NUM_DISPLAYS-1:0]      digit_en,
  output logic                         frame_start
);

  localparam int unsigned IDX_W = (NUM_DISPLAYS > 1) ? $clog2(NUM_DISPLAYS) : 1;

  localparam logic [SCAN_DIVISIONBITS-1:0] CNT_MAX   = '1;
  localparam logic [IDX_W-1:0]             IDX_LAST  = IDX_W'(NUM_DISPLAYS - 1);
  localparam logic [6:0]                   SEG_OFF   = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DISPLAYS-1:0]      DIGIT_OFF = {NUM_DISPLAYS{DIGIT_ACTIVE_LOW}};

  // Reject impossible configurations at elaboration rather than building odd hardware.
  if (NUM_DISPLAYS < 1) begin : g_bad_num_displays
    $error("sevenseg_scan_mux: NUM_DISPLAYS must be at least 1");
  end
  if (SCAN_DIVISIONBITS < 2) begin : g_bad_divisionbits
    $error("sevenseg_scan_mux: SCAN_DIVISIONBITS must be at least 2");
  end
  if ((DEADTIME_CYCLES >> SCAN_DIVISIONBITS) != 0) begin : g_bad_deadtime
    $error("sevenseg_scan_mux: DEADTIME_CYCLES must be shorter than one digit slot");
  end

  logic [SCAN_DIVISIONBITS-1:0] cnt;
  logic [IDX_W-1:0]             idx;
  logic [NUM_DISPLAYS-1:0][6:0] snap;

  logic                         last_in_slot;
  logic                         last_in_frame;
  logic                         blank;
  logic [NUM_DISPLAYS-1:0]      onehot;
  logic [6:0]                   seg_d;
  logic [NUM_DISPLAYS-1:0]      digit_en_d;

  assign last_in_slot  = (cnt == CNT_MAX);
  assign last_in_frame = last_in_slot && (idx == IDX_LAST);

`ifdef SEVENSEG_DEADTIME_EN
  localparam logic [SCAN_DIVISIONBITS-1:0] DEAD = SCAN_DIVISIONBITS'(DEADTIME_CYCLES);

  // A zero-length deadtime would be a compare against zero that never fires.
  if (DEADTIME_CYCLES > 0) begin : g_deadtime
    assign blank = (cnt < DEAD);
  end else begin : g_no_deadtime
    assign blank = 1'b0;
  end
`else
  assign blank = 1'b0;
`endif

  // NOTE: always_comb gives every output a default first, so no path can infer a latch.
  always_comb begin
    onehot     = NUM_DISPLAYS'(1) << idx;
    seg_d      = SEG_OFF;
    digit_en_d = DIGIT_OFF;
    if (!blank) begin
      seg_d      = snap[idx] ^ SEG_OFF;
      digit_en_d = onehot ^ DIGIT_OFF;
    end
  end

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  // NOTE: snap is a small register bank, not a RAM, so it is reset with everything else;
  // that is what makes the first frame after reset come out blank.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt         <= '0;
      idx         <= '0;
      snap        <= '0;
      seg         <= SEG_OFF;
      digit_en    <= DIGIT_OFF;
      frame_start <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (last_in_slot) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      // Capture only at the frame boundary so a frame never mixes old and new digits.
      if (last_in_frame) begin
        snap <= data;
      end
      frame_start <= (cnt == '0) && (idx == '0);
      seg         <= seg_d;
      digit_en    <= digit_en_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// Scoreboard bench for sevenseg_scan_mux: a cycle-count reference model queues expected
// pin values for a 2-digit and a 1-digit instance; a negedge monitor compares them.
module tb_sevenseg_scan_mux;

  localparam int S0 = 8;          // slot length for both instances (2**3)
  localparam int N0 = 2;
  localparam int N1 = 1;
  localparam int DEAD = 2;

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] en;
    logic       fs;
  } exp_t;

  logic              clk = 1'b0;
  logic              n_reset;
  logic [1:0][6:0]   data0;
  logic [0:0][6:0]   data1;
  logic [6:0]        seg0, seg1;
  logic [1:0]        en0;
  logic [0:0]        en1;
  logic              fs0, fs1;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sevenseg_scan_mux #(
    .NUM_DISPLAYS(N0), .SCAN_DIVISIONBITS(3), .DEADTIME_CYCLES(DEAD),
    .SEG_ACTIVE_LOW(1'b1), .DIGIT_ACTIVE_LOW(1'b1)
  ) dut0 (
    .clk(clk), .n_reset(n_reset), .data(data0),
    .seg(seg0), .digit_en(en0), .frame_start(fs0)
  );

  sevenseg_scan_mux #(
    .NUM_DISPLAYS(N1), .SCAN_DIVISIONBITS(3), .DEADTIME_CYCLES(DEAD),
    .SEG_ACTIVE_LOW(1'b0), .DIGIT_ACTIVE_LOW(1'b0)
  ) dut1 (
    .clk(clk), .n_reset(n_reset), .data(data1),
    .seg(seg1), .digit_en(en1), .frame_start(fs1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t reset_out(input bit sal, input bit dal);
    exp_t r;
    r.seg = {7{sal}};
    r.en  = {2{dal}};
    r.fs  = 1'b0;
    return r;
  endfunction

  // Output after the e-th rising edge since reset release, from the scan arithmetic.
  function automatic exp_t model_out(input int e, input int n, input bit sal, input bit dal,
                                     input logic [1:0][6:0] snap);
    exp_t r;
    int   pos  = e % S0;
    int   dig  = (e / S0) % n;
    bit   blnk = 1'b0;
`ifdef SEVENSEG_DEADTIME_EN
    blnk = (pos < DEAD);
`endif
    r.fs  = ((e % (n * S0)) == 0);
    r.seg = {7{sal}};
    r.en  = 2'b00;
    if (!blnk) begin
      r.seg     = snap[dig] ^ {7{sal}};
      r.en[dig] = 1'b1;
    end
    r.en = r.en ^ {2{dal}};
    return r;
  endfunction

  // Reference model: one expectation per rising edge, including async reset effects.
  initial begin
    int              e0 = 0;
    int              e1 = 0;
    logic [1:0][6:0] snap0 = '0;
    logic [1:0][6:0] snap1 = '0;
    logic            r_at;
    logic [1:0][6:0] d0_at, d1_at;
    forever begin
      @(posedge clk);
      r_at  = n_reset;
      d0_at = data0;
      d1_at = {7'h00, data1[0]};
      #2;
      if (!r_at || !n_reset) begin
        e0 = 0; e1 = 0; snap0 = '0; snap1 = '0;
        q0.push_back(reset_out(1'b1, 1'b1));
        q1.push_back(reset_out(1'b0, 1'b0));
      end else begin
        q0.push_back(model_out(e0, N0, 1'b1, 1'b1, snap0));
        q1.push_back(model_out(e1, N1, 1'b0, 1'b0, snap1));
        if (e0 % (N0 * S0) == N0 * S0 - 1) snap0 = d0_at;
        if (e1 % (N1 * S0) == N1 * S0 - 1) snap1 = d1_at;
        e0++;
        e1++;
      end
    end
  end

  // Monitor: samples away from the active edge and pops one expectation per DUT.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q0.size() == 0 || q1.size() == 0) begin
        check("scoreboard_underflow", 32'(q0.size() + q1.size()), 32'd2);
      end else begin
        x = q0.pop_front();
        check("d2_seg",         32'(seg0), 32'(x.seg));
        check("d2_digit_en",    32'(en0),  32'(x.en));
        check("d2_frame_start", 32'(fs0),  32'(x.fs));
        x = q1.pop_front();
        check("d1_seg",         32'(seg1), 32'(x.seg));
        check("d1_digit_en",    32'(en1),  32'(x.en[0]));
        check("d1_frame_start", 32'(fs1),  32'(x.fs));
      end
    end
  end

  // Stimulus: every change lands 1 time unit after a rising edge.
  initial begin
    n_reset  = 1'b0;
    data0[1] = 7'h06;
    data0[0] = 7'h3F;
    data1[0] = 7'h7F;
    repeat (4) @(posedge clk);
    #1 n_reset = 1'b1;

    // Mid-frame-2 change of digit 0 must stay invisible until frame 3.
    repeat (20) @(posedge clk);
    #1 data0[0] = 7'h5B;
    repeat (28) @(posedge clk);

    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(3) == 0) data0[$urandom_range(1)] = 7'($urandom);
      if ($urandom_range(3) == 0) data1[0] = 7'($urandom);
    end

    // 112 edges so far; 13 more leaves the last edge at slot 1, cnt 4 (digit 1 DRIVE).
    repeat (13) @(posedge clk);
    #1 n_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_reset = 1'b1;
    data0[1] = 7'h4F;
    data0[0] = 7'h66;
    data1[0] = 7'h7F;
    repeat (40) @(posedge clk);

    repeat (2) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
